imm_decode_stage: RTL and testbench

Parametrised, registered immediate decoder for the decode stage of the RISC-V core. It takes a raw fetched instruction word (32-bit or 16-bit compressed), extracts and sign- or zero-extends the immediate to XLEN, and classifies its format. The result is held in a single pipeline register behind a valid/ready handshake with flush. It replaces the combinational pre-sliced-field immediate generator: the bit scrambling moves inside the block, and RVC and CSR-immediate formats are added.

---
 rtl/imm_pkg.sv | 30 +++
 rtl/rvc_imm_dec.sv | 113 +++++++++++
 rtl/imm_decode_stage.sv | 129 ++++++++++++
 tb/tb_imm_decode_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared types and constants for the decode-stage immediate generator.
package imm_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned RVC_W    = 16;
    localparam int unsigned OPCODE_W = 7;

    // Immediate format reported alongside the extended value.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5,
        Z    = 3'd6
    } imm_type_e;

    // Major opcodes (instr[6:0]) that carry an immediate.
    localparam logic [OPCODE_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] SYSTEM = 7'b1110011;

endpackage

// File: rtl/rvc_imm_dec.sv
// Combinational RVC immediate decoder: maps a 16-bit compressed encoding to
// the immediate and format of its equivalent 32-bit instruction.
// No legality checking; reserved encodings simply decode as whatever they
// alias to, or NONE.
module rvc_imm_dec
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [RVC_W-1:0] instr,
    output logic [XLEN-1:0]  imm_c,
    output imm_type_e        imm_type_c
);

    logic [1:0] quad;
    logic [2:0] funct3;

    assign quad   = instr[1:0];
    assign funct3 = instr[15:13];

    // Quadrant/funct3 decode with per-format bit gathering and extension.
    always_comb begin
        imm_c      = '0;
        imm_type_c = NONE;
        case (quad)
            2'b00: begin
                case (funct3)
                    3'b000: begin // c.addi4spn
                        imm_c      = XLEN'({instr[10:7], instr[12:11], instr[5], instr[6], 2'b00});
                        imm_type_c = I;
                    end
                    3'b010: begin // c.lw
                        imm_c      = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
                        imm_type_c = I;
                    end
                    3'b110: begin // c.sw
                        imm_c      = XLEN'({instr[5], instr[12:10], instr[6], 2'b00});
                        imm_type_c = S;
                    end
                    default: ;
                endcase
            end
            2'b01: begin
                case (funct3)
                    3'b000, 3'b010: begin // c.addi, c.li
                        imm_c      = XLEN'($signed({instr[12], instr[6:2]}));
                        imm_type_c = I;
                    end
                    3'b001: begin // c.jal on RV32; c.addiw on RV64 is not reported
                        if (XLEN == 32) begin
                            imm_c      = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6],
                                                        instr[7], instr[2], instr[11], instr[5:3], 1'b0}));
                            imm_type_c = J;
                        end
                    end
                    3'b011: begin
                        if (instr[11:7] == 5'd2) begin // c.addi16sp
                            imm_c      = XLEN'($signed({instr[12], instr[4:3], instr[5], instr[2],
                                                        instr[6], 4'b0000}));
                            imm_type_c = I;
                        end else begin // c.lui
                            imm_c      = XLEN'($signed({instr[12], instr[6:2], 12'h000}));
                            imm_type_c = U;
                        end
                    end
                    3'b100: begin
                        case (instr[11:10])
                            2'b00, 2'b01: begin // c.srli, c.srai
                                imm_c      = XLEN'({instr[12], instr[6:2]});
                                imm_type_c = I;
                            end
                            2'b10: begin // c.andi
                                imm_c      = XLEN'($signed({instr[12], instr[6:2]}));
                                imm_type_c = I;
                            end
                            default: ;
                        endcase
                    end
                    3'b101: begin // c.j
                        imm_c      = XLEN'($signed({instr[12], instr[8], instr[10:9], instr[6],
                                                    instr[7], instr[2], instr[11], instr[5:3], 1'b0}));
                        imm_type_c = J;
                    end
                    3'b110, 3'b111: begin // c.beqz, c.bnez
                        imm_c      = XLEN'($signed({instr[12], instr[6:5], instr[2], instr[11:10],
                                                    instr[4:3], 1'b0}));
                        imm_type_c = B;
                    end
                    default: ;
                endcase
            end
            2'b10: begin
                case (funct3)
                    3'b000: begin // c.slli
                        imm_c      = XLEN'({instr[12], instr[6:2]});
                        imm_type_c = I;
                    end
                    3'b010: begin // c.lwsp
                        imm_c      = XLEN'({instr[3:2], instr[12], instr[6:4], 2'b00});
                        imm_type_c = I;
                    end
                    3'b110: begin // c.swsp
                        imm_c      = XLEN'({instr[8:7], instr[12:9], 2'b00});
                        imm_type_c = S;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate decoder for the decode stage: extracts and extends the
// immediate of a raw instruction and holds it behind a valid/ready register.
// Define IMM_DECODE_RVC_EN to include compressed (RVC) immediate decode.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic                flush_i,
    output logic [XLEN-1:0]     imm_o,
    output imm_type_e           imm_type_o,
    output logic                is_rvc_o,
    output logic                imm_valid_o,
    input  logic                imm_ready_i
);

    logic [OPCODE_W-1:0] opcode;
    logic                compressed_c;
    logic                accept_c;
    logic [XLEN-1:0]     dec32_imm_c;
    imm_type_e           dec32_type_c;
    logic [XLEN-1:0]     dec_imm_c;
    imm_type_e           dec_type_c;

    assign opcode       = instr_i[OPCODE_W-1:0];
    assign compressed_c = (instr_i[1:0] != 2'b11);

    assign instr_ready_o = !imm_valid_o || imm_ready_i;
    assign accept_c      = instr_valid_i && instr_ready_o && !flush_i;

    // Full-width instruction: opcode to format, standard bit placement.
    always_comb begin
        dec32_imm_c  = '0;
        dec32_type_c = NONE;
        case (opcode)
            OP_IMM, LOAD, JALR: begin
                dec32_imm_c  = XLEN'($signed(instr_i[31:20]));
                dec32_type_c = I;
            end
            STORE: begin
                dec32_imm_c  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
                dec32_type_c = S;
            end
            BRANCH: begin
                dec32_imm_c  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                              instr_i[11:8], 1'b0}));
                dec32_type_c = B;
            end
            LUI, AUIPC: begin
                dec32_imm_c  = XLEN'($signed({instr_i[31:12], 12'h000}));
                dec32_type_c = U;
            end
            JAL: begin
                dec32_imm_c  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                              instr_i[30:21], 1'b0}));
                dec32_type_c = J;
            end
            SYSTEM: begin
                if (instr_i[14]) begin
                    dec32_imm_c  = XLEN'(instr_i[19:15]);
                    dec32_type_c = Z;
                end
            end
            default: ;
        endcase
    end

`ifdef IMM_DECODE_RVC_EN
    logic [XLEN-1:0] rvc_imm_c;
    imm_type_e       rvc_type_c;
    logic            is_rvc_q;

    rvc_imm_dec #(
        .XLEN (XLEN)
    ) u_rvc_imm_dec (
        .instr      (instr_i[RVC_W-1:0]),
        .imm_c      (rvc_imm_c),
        .imm_type_c (rvc_type_c)
    );

    assign dec_imm_c  = compressed_c ? rvc_imm_c  : dec32_imm_c;
    assign dec_type_c = compressed_c ? rvc_type_c : dec32_type_c;

    // Compressed flag travels with the held immediate.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_rvc_q <= 1'b0;
        end else if (accept_c) begin
            is_rvc_q <= compressed_c;
        end
    end

    assign is_rvc_o = is_rvc_q;
`else
    assign dec_imm_c  = compressed_c ? '0   : dec32_imm_c;
    assign dec_type_c = compressed_c ? NONE : dec32_type_c;
    assign is_rvc_o   = 1'b0;
`endif

    // Output valid: flush beats accept, accept beats drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_valid_o <= 1'b0;
        end else if (flush_i) begin
            imm_valid_o <= 1'b0;
        end else if (accept_c) begin
            imm_valid_o <= 1'b1;
        end else if (imm_ready_i) begin
            imm_valid_o <= 1'b0;
        end
    end

    // Data register loads only on accept and otherwise holds its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            imm_o      <= '0;
            imm_type_o <= NONE;
        end else if (accept_c) begin
            imm_o      <= dec_imm_c;
            imm_type_o <= dec_type_c;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage (XLEN=32); expectations follow the
// IMM_DECODE_RVC_EN setting of the build.
module tb_imm_decode_stage;
    import imm_pkg::*;

    localparam int unsigned XLEN = 32;
`ifdef IMM_DECODE_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [31:0]     instr_i;
    logic            instr_valid_i;
    logic            instr_ready_o;
    logic            flush_i;
    logic [XLEN-1:0] imm_o;
    imm_type_e       imm_type_o;
    logic            is_rvc_o;
    logic            imm_valid_o;
    logic            imm_ready_i;

    int checks = 0;
    int errors = 0;

    imm_decode_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .flush_i       (flush_i),
        .imm_o         (imm_o),
        .imm_type_o    (imm_type_o),
        .is_rvc_o      (is_rvc_o),
        .imm_valid_o   (imm_valid_o),
        .imm_ready_i   (imm_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] e_imm, input imm_type_e e_type,
                           input logic e_valid, input logic e_rvc);
        chk({tag, ".imm"},   64'(imm_o),       64'(e_imm));
        chk({tag, ".type"},  64'(imm_type_o),  64'(e_type));
        chk({tag, ".valid"}, 64'(imm_valid_o), 64'(e_valid));
        chk({tag, ".rvc"},   64'(is_rvc_o),    64'(e_rvc));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] s_instr [8];
    logic [31:0] s_imm   [8];
    imm_type_e   s_type  [8];
    logic [31:0] c_instr [3];
    logic [31:0] c_imm   [3];
    imm_type_e   c_type  [3];

    initial begin
        s_instr[0] = 32'hFFF00093; s_imm[0] = 32'hFFFFFFFF; s_type[0] = I;
        s_instr[1] = 32'hFE20AE23; s_imm[1] = 32'hFFFFFFFC; s_type[1] = S;
        s_instr[2] = 32'hFE000CE3; s_imm[2] = 32'hFFFFFFF8; s_type[2] = B;
        s_instr[3] = 32'h123452B7; s_imm[3] = 32'h12345000; s_type[3] = U;
        s_instr[4] = 32'h001000EF; s_imm[4] = 32'h00000800; s_type[4] = J;
        s_instr[5] = 32'h300FD073; s_imm[5] = 32'h0000001F; s_type[5] = Z;
        s_instr[6] = 32'h00000033; s_imm[6] = 32'h00000000; s_type[6] = NONE;
        s_instr[7] = 32'h80002083; s_imm[7] = 32'hFFFFF800; s_type[7] = I;

        // c.li x1,-1 with junk upper half; c.j -2; c.lwsp x1,4(sp)
        c_instr[0] = 32'hDEAD50FD; c_imm[0] = RVC ? 32'hFFFFFFFF : 32'h0; c_type[0] = RVC ? I : NONE;
        c_instr[1] = 32'h0000BFFD; c_imm[1] = RVC ? 32'hFFFFFFFE : 32'h0; c_type[1] = RVC ? J : NONE;
        c_instr[2] = 32'h00004092; c_imm[2] = RVC ? 32'h00000004 : 32'h0; c_type[2] = RVC ? I : NONE;

        rst = 1'b1; instr_i = '0; instr_valid_i = 1'b0; flush_i = 1'b0; imm_ready_i = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk_out("reset", 32'h0, NONE, 1'b0, 1'b0);
        chk("reset.ready", 64'(instr_ready_o), 64'd1);

        // Back-to-back 32-bit stream, one result per cycle.
        instr_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            instr_i = s_instr[i];
            tick();
            chk_out($sformatf("stream%0d", i), s_imm[i], s_type[i], 1'b1, 1'b0);
        end

        // Compressed encodings.
        for (int i = 0; i < 3; i++) begin
            instr_i = c_instr[i];
            tick();
            chk_out($sformatf("rvc%0d", i), c_imm[i], c_type[i], 1'b1, RVC);
        end

        // Backpressure: accept addi, then stall with lui queued.
        instr_i = s_instr[0];
        tick();
        chk_out("bp.first", 32'hFFFFFFFF, I, 1'b1, 1'b0);
        imm_ready_i = 1'b0;
        instr_i     = s_instr[3];
        #1;
        chk("bp.ready_low", 64'(instr_ready_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out($sformatf("bp.hold%0d", i), 32'hFFFFFFFF, I, 1'b1, 1'b0);
            chk($sformatf("bp.hold%0d.ready", i), 64'(instr_ready_o), 64'd0);
        end
        imm_ready_i = 1'b1;
        #1;
        chk("bp.ready_high", 64'(instr_ready_o), 64'd1);
        tick();
        chk_out("bp.release", 32'h12345000, U, 1'b1, 1'b0);

        // Flush while stalled with a new instruction presented.
        imm_ready_i = 1'b0;
        instr_i     = s_instr[4];
        tick();
        chk_out("fl.stall", 32'h12345000, U, 1'b1, 1'b0);
        flush_i = 1'b1;
        tick();
        chk_out("fl.flushed", 32'h12345000, U, 1'b0, 1'b0);
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        imm_ready_i   = 1'b1;
        tick();
        chk_out("fl.dropped", 32'h12345000, U, 1'b0, 1'b0);
        tick();
        chk_out("fl.idle", 32'h12345000, U, 1'b0, 1'b0);

        // Reset mid-operation with a new instruction presented.
        instr_valid_i = 1'b1;
        imm_ready_i   = 1'b0;
        instr_i       = s_instr[0];
        tick();
        chk_out("rm.loaded", 32'hFFFFFFFF, I, 1'b1, 1'b0);
        rst         = 1'b1;
        imm_ready_i = 1'b1;
        instr_i     = s_instr[1];
        tick();
        chk_out("rm.reset", 32'h0, NONE, 1'b0, 1'b0);
        rst           = 1'b0;
        instr_valid_i = 1'b0;
        tick();
        chk_out("rm.after", 32'h0, NONE, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
